// File: rtl/sprite_blitter.sv
// Copies a rectangular window of an image ROM into the OLED framebuffer,
// with a transparent colour key and clipping of off-screen pixels.
module sprite_blitter #(
    parameter int SCREEN_W = 96,
    parameter int SCREEN_H = 64,
    parameter int IDX_W    = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       src_x,
    input  logic [5:0]       src_y,
    input  logic [6:0]       win_w,
    input  logic [5:0]       win_h,
    input  logic [7:0]       dst_x,
    input  logic [6:0]       dst_y,
    input  logic             key_en,
    input  logic [15:0]      key_colour,
    output logic [IDX_W-1:0] pixel_index,
    input  logic [15:0]      oled_colour,
    output logic             fb_we,
    output logic [IDX_W-1:0] fb_addr,
    output logic [15:0]      fb_data,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [6:0]       cx_q, cx_d;
    logic [5:0]       cy_q, cy_d;
    logic [6:0]       dcx_q, dcx_d;
    logic [5:0]       dcy_q, dcy_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
    logic             fb_we_q, fb_we_d;
    logic [IDX_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]      fb_data_q, fb_data_d;

    logic [6:0]       src_x_q, src_x_d;
    logic [5:0]       src_y_q, src_y_d;
    logic [6:0]       win_w_q, win_w_d;
    logic [5:0]       win_h_q, win_h_d;
    logic [7:0]       dst_x_q, dst_x_d;
    logic [6:0]       dst_y_q, dst_y_d;
    logic             key_en_q, key_en_d;
    logic [15:0]      key_colour_q, key_colour_d;

    logic [8:0]       px, py;
    logic             on_screen, keyed;

    // Source coordinates wrap around the image, so the row-major index never leaves the ROM.
    function automatic logic [IDX_W-1:0] src_index(input logic [6:0] sx0, input logic [5:0] sy0,
                                                   input logic [6:0] cx, input logic [5:0] cy);
        logic [7:0] col;
        logic [6:0] row;
        col = {1'b0, sx0} + {1'b0, cx};
        if (col >= 8'(SCREEN_W)) col = col - 8'(SCREEN_W);
        if (col >= 8'(SCREEN_W)) col = col - 8'(SCREEN_W);
        row = {1'b0, sy0} + {1'b0, cy};
        if (row >= 7'(SCREEN_H)) row = row - 7'(SCREEN_H);
        return IDX_W'(row) * IDX_W'(SCREEN_W) + IDX_W'(col);
    endfunction

    always_comb begin
        px        = {dst_x_q[7], dst_x_q} + {2'b00, dcx_q};
        py        = {{2{dst_y_q[6]}}, dst_y_q} + {3'b000, dcy_q};
        on_screen = !px[8] && (px[7:0] < 8'(SCREEN_W)) && !py[8] && (py[7:0] < 8'(SCREEN_H));
        keyed     = key_en_q && (oled_colour == key_colour_q);
    end

    always_comb begin
        state_d       = state_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        dcx_d         = cx_q;
        dcy_d         = cy_q;
        valid_d       = 1'b0;
        pixel_index_d = pixel_index_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        src_x_d       = src_x_q;
        src_y_d       = src_y_q;
        win_w_d       = win_w_q;
        win_h_d       = win_h_q;
        dst_x_d       = dst_x_q;
        dst_y_d       = dst_y_q;
        key_en_d      = key_en_q;
        key_colour_d  = key_colour_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_x_d      = src_x;
                    src_y_d      = src_y;
                    win_w_d      = win_w;
                    win_h_d      = win_h;
                    dst_x_d      = dst_x;
                    dst_y_d      = dst_y;
                    key_en_d     = key_en;
                    key_colour_d = key_colour;
                    cx_d         = 7'd0;
                    cy_d         = 6'd0;
                    // An empty window still spends one busy cycle so done always lands at w*h+2.
                    if (win_w == 7'd0 || win_h == 6'd0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d       = ST_RUN;
                        pixel_index_d = src_index(src_x, src_y, 7'd0, 6'd0);
                    end
                end
            end
            ST_RUN: begin
                valid_d = 1'b1;
                if (cx_q + 7'd1 == win_w_q) begin
                    if (cy_q + 6'd1 == win_h_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cx_d = 7'd0;
                        cy_d = cy_q + 6'd1;
                    end
                end else begin
                    cx_d = cx_q + 7'd1;
                end
                if (state_d == ST_RUN) begin
                    pixel_index_d = src_index(src_x_q, src_y_q, cx_d, cy_d);
                end
            end
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // The ROM colour for last cycle's issue arrives now; the write is registered.
        if (valid_q && on_screen && !keyed) begin
            fb_we_d   = 1'b1;
            fb_addr_d = IDX_W'(py[7:0]) * IDX_W'(SCREEN_W) + IDX_W'(px[7:0]);
            fb_data_d = oled_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cx_q          <= 7'd0;
            cy_q          <= 6'd0;
            dcx_q         <= 7'd0;
            dcy_q         <= 6'd0;
            valid_q       <= 1'b0;
            pixel_index_q <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= 16'd0;
            src_x_q       <= 7'd0;
            src_y_q       <= 6'd0;
            win_w_q       <= 7'd0;
            win_h_q       <= 6'd0;
            dst_x_q       <= 8'd0;
            dst_y_q       <= 7'd0;
            key_en_q      <= 1'b0;
            key_colour_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            dcx_q         <= dcx_d;
            dcy_q         <= dcy_d;
            valid_q       <= valid_d;
            pixel_index_q <= pixel_index_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            src_x_q       <= src_x_d;
            src_y_q       <= src_y_d;
            win_w_q       <= win_w_d;
            win_h_q       <= win_h_d;
            dst_x_q       <= dst_x_d;
            dst_y_q       <= dst_y_d;
            key_en_q      <= key_en_d;
            key_colour_q  <= key_colour_d;
        end
    end

    assign pixel_index = pixel_index_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_FIN);

endmodule
